// File: rtl/jt03_seq_pkg.sv
// Shared constants and the decoded-slot bundle for the YM2203 slot sequencer.
package jt03_seq_pkg;

   localparam int NUM_SLOTS = 12;

   localparam logic [1:0] OP_S1 = 2'd0;
   localparam logic [1:0] OP_S3 = 2'd1;
   localparam logic [1:0] OP_S2 = 2'd2;
   localparam logic [1:0] OP_S4 = 2'd3;

   // fv records whether a full frame had completed when the slot was decoded.
   typedef struct packed {
      logic [1:0] ch;
      logic [1:0] op;
      logic [3:0] enters;
      logic       zero;
      logic [2:0] alg;
      logic       fv;
   } slot_bundle_t;

   // enters[0]=S1, [1]=S2, [2]=S3, [3]=S4
   function automatic logic [3:0] op_enters(input logic [1:0] op);
      case (op)
         OP_S1:   return 4'b0001;
         OP_S2:   return 4'b0010;
         OP_S3:   return 4'b0100;
         default: return 4'b1000;
      endcase
   endfunction

endpackage

// File: rtl/jt03_seq_dly.sv
// Generic DLY-stage shift register advanced on clk_en; DLY=0 is a plain wire.
module jt03_seq_dly #(
   parameter int W   = 8,
   parameter int DLY = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clk_en,
   input  logic [W-1:0] i_d,
   output logic [W-1:0] o_q
);

   generate
      if (DLY == 0) begin : g_comb
         assign o_q = i_d;
      end else begin : g_pipe
         logic [W-1:0] r_sr [DLY];

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int i = 0; i < DLY; i++) r_sr[i] <= '0;
            end else if (clk_en) begin
               r_sr[0] <= i_d;
               for (int i = 1; i < DLY; i++) r_sr[i] <= r_sr[i-1];
            end
         end

         assign o_q = r_sr[DLY-1];
      end
   endgenerate

endmodule

// File: rtl/jt03_slot_seq.sv
// YM2203 slot sequencer: slot counter, per-channel algorithm registers, delayed decode.
// Build option JT03_ALG_SHADOW_EN: algorithm changes take effect only at frame wrap.
module jt03_slot_seq
   import jt03_seq_pkg::*;
#(
   parameter int PIPE_DLY = 2,
   parameter int NUM_CH   = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clk_en,
   input  logic       wr_en,
   input  logic [1:0] wr_ch,
   input  logic [2:0] wr_alg,
   output logic [3:0] slot,
   output logic [1:0] ch,
   output logic [1:0] op,
   output logic       s1_enters,
   output logic       s2_enters,
   output logic       s3_enters,
   output logic       s4_enters,
   output logic       zero,
   output logic [2:0] alg,
   output logic       sample
);

   logic [3:0]   r_slot;
   logic         r_frame_valid;
   logic [2:0]   r_alg_pend [NUM_CH];
   logic [2:0]   w_alg_act  [NUM_CH];
   logic         w_last;
   logic         w_wr_ok;
   slot_bundle_t w_dec;
   slot_bundle_t w_out;

   assign w_last  = (r_slot == 4'(NUM_SLOTS - 1));
   assign w_wr_ok = wr_en && (32'(wr_ch) < NUM_CH);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_slot        <= '0;
         r_frame_valid <= 1'b0;
      end else if (clk_en) begin
         r_slot <= w_last ? 4'd0 : r_slot + 4'd1;
         if (w_last) r_frame_valid <= 1'b1;
      end
   end

   // Register writes are CPU-side and do not wait for clk_en.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_CH; i++) r_alg_pend[i] <= '0;
      end else if (w_wr_ok) begin
         r_alg_pend[wr_ch] <= wr_alg;
      end
   end

`ifdef JT03_ALG_SHADOW_EN
   logic [2:0] r_alg_act [NUM_CH];

   // A write landing on the wrap clock bypasses the pending copy so it is not lost for a frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_CH; i++) r_alg_act[i] <= '0;
      end else if (clk_en && w_last) begin
         for (int i = 0; i < NUM_CH; i++)
            r_alg_act[i] <= (w_wr_ok && wr_ch == 2'(i)) ? wr_alg : r_alg_pend[i];
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_CH; i++) w_alg_act[i] = r_alg_act[i];
   end
`else
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) w_alg_act[i] = r_alg_pend[i];
   end
`endif

   always_comb begin
      w_dec        = '0;
      w_dec.op     = 2'(r_slot / 4'(NUM_CH));
      w_dec.ch     = 2'(r_slot % 4'(NUM_CH));
      w_dec.enters = op_enters(w_dec.op);
      w_dec.zero   = (r_slot == 4'd0);
      w_dec.alg    = w_alg_act[w_dec.ch];
      w_dec.fv     = r_frame_valid;
   end

   jt03_seq_dly #(
      .W   ($bits(slot_bundle_t)),
      .DLY (PIPE_DLY)
   ) u_dly (
      .clk    (clk),
      .rst_n  (rst_n),
      .clk_en (clk_en),
      .i_d    (w_dec),
      .o_q    (w_out)
   );

   assign slot      = r_slot;
   assign ch        = w_out.ch;
   assign op        = w_out.op;
   assign s1_enters = w_out.enters[0];
   assign s2_enters = w_out.enters[1];
   assign s3_enters = w_out.enters[2];
   assign s4_enters = w_out.enters[3];
   assign zero      = w_out.zero;
   assign alg       = w_out.alg;
   // The first frame after reset has no accumulated data behind it.
   assign sample    = w_out.zero & w_out.fv;

endmodule

// File: tb/tb_jt03_slot_seq.sv
// Scoreboard bench for jt03_slot_seq: tick-count reference model, queued expectations, monitor.
module tb_jt03_slot_seq;
   import jt03_seq_pkg::*;

   localparam int DLY = 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       clk_en = 1'b0;
   logic       wr_en = 1'b0;
   logic [1:0] wr_ch = '0;
   logic [2:0] wr_alg = '0;
   logic [3:0] slot;
   logic [1:0] ch, op;
   logic       s1_enters, s2_enters, s3_enters, s4_enters, zero, sample;
   logic [2:0] alg;

   jt03_slot_seq #(.PIPE_DLY(DLY), .NUM_CH(3)) u_dut (
      .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .wr_en(wr_en), .wr_ch(wr_ch),
      .wr_alg(wr_alg), .slot(slot), .ch(ch), .op(op), .s1_enters(s1_enters),
      .s2_enters(s2_enters), .s3_enters(s3_enters), .s4_enters(s4_enters),
      .zero(zero), .alg(alg), .sample(sample)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0] slot;
      logic [1:0] ch;
      logic [1:0] op;
      logic [3:0] ent;   // {s4,s3,s2,s1}
      logic       zero;
      logic [2:0] alg;
      logic       sample;
   } obs_t;

   obs_t exp_q[$];
   int   n_chk = 0;
   int   n_fail = 0;
   int   n_pop = 0;

   // Reference model: enabled ticks since reset plus the alg value seen at each tick.
   int n_tick;
   int pend[3];
   int act[3];
   int hist[$];

   // Operator group number by position in the frame: S1, S3, S2, S4.
   function automatic int grp(input int pos);
      case (pos)
         0: return 1;
         1: return 3;
         2: return 2;
         default: return 4;
      endcase
   endfunction

   function automatic obs_t model_out();
      obs_t e;
      int   k, s;
      e = '0;
      e.slot = 4'(n_tick % 12);
      if (n_tick >= DLY) begin
         k = n_tick - DLY;
         s = k % 12;
         e.op     = 2'(s / 3);
         e.ch     = 2'(s % 3);
         e.ent    = 4'(1 << (grp(s / 3) - 1));
         e.zero   = (s == 0);
         e.alg    = 3'((k < hist.size()) ? hist[k] : act[s % 3]);
         e.sample = (s == 0) && (k >= 12);
      end
      return e;
   endfunction

   task automatic model_reset();
      n_tick = 0;
      for (int i = 0; i < 3; i++) begin
         pend[i] = 0;
         act[i]  = 0;
      end
      hist.delete();
   endtask

   task automatic model_clock(input bit en, input bit we, input int wch, input int walg);
      if (en) hist.push_back(act[(n_tick % 12) % 3]);
`ifdef JT03_ALG_SHADOW_EN
      if (en && (n_tick % 12 == 11))
         for (int i = 0; i < 3; i++) act[i] = (we && wch == i) ? walg : pend[i];
`endif
      if (we && wch < 3) pend[wch] = walg;
`ifndef JT03_ALG_SHADOW_EN
      for (int i = 0; i < 3; i++) act[i] = pend[i];
`endif
      if (en) n_tick++;
   endtask

   function automatic obs_t observed();
      obs_t o;
      o.slot   = slot;
      o.ch     = ch;
      o.op     = op;
      o.ent    = {s4_enters, s3_enters, s2_enters, s1_enters};
      o.zero   = zero;
      o.alg    = alg;
      o.sample = sample;
      return o;
   endfunction

   task automatic chk(input string name, input obs_t got, input obs_t exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s t=%0t: got slot=%0d ch=%0d op=%0d ent=%b zero=%b alg=%0d sample=%b | need slot=%0d ch=%0d op=%0d ent=%b zero=%b alg=%0d sample=%b",
                  name, $time, got.slot, got.ch, got.op, got.ent, got.zero, got.alg, got.sample,
                  exp.slot, exp.ch, exp.op, exp.ent, exp.zero, exp.alg, exp.sample);
      end
   endtask

   // Drive one clock of stimulus and queue the state expected after its rising edge.
   task automatic step(input bit en, input bit we, input int wch, input int walg);
      @(negedge clk);
      clk_en = en;
      wr_en  = we;
      wr_ch  = 2'(wch);
      wr_alg = 3'(walg);
      model_clock(en, we, wch, walg);
      exp_q.push_back(model_out());
   endtask

   initial begin : monitor
      obs_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_pop++;
            chk("seq", observed(), e);
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin : stim
      model_reset();
      repeat (3) @(negedge clk);
      chk("reset", observed(), model_out());
      rst_n = 1'b1;

      repeat (26) step(1, 0, 0, 0);
      for (int i = 0; i < 30; i++) step(i % 2 == 0, 0, 0, 0);

      step(1, 1, 3, 7);
      repeat (20) step(1, 0, 0, 0);

      while (n_tick % 12 != 4) step(1, 0, 0, 0);
      step(1, 1, 1, 5);
      repeat (30) step(1, 0, 0, 0);

      repeat (300)
         step($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
              $urandom_range(0, 3), $urandom_range(0, 7));

      while (n_tick % 12 != 6) step(1, 0, 0, 0);
      step(1, 1, 2, 6);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      model_reset();
      chk("async_reset", observed(), model_out());
      clk_en = 1'b0;
      wr_en  = 1'b0;
      @(negedge clk);
      chk("reset_hold", observed(), model_out());
      @(negedge clk);
      rst_n = 1'b1;
      repeat (30) step(1, 0, 0, 0);

      @(negedge clk);
      @(negedge clk);
      n_chk++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d expectations left, need 0", exp_q.size());
      end
      n_chk++;
      if (n_pop < 400) begin
         n_fail++;
         $display("FAIL pop_count: got %0d, need at least 400", n_pop);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
